// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
//   in_valid, in_ready : input-side handshake
//   in1, in2, sgn      : operands and per-transaction signed-mode flag
//   out_valid, out_ready : output-side handshake
//   out                : W1+1 bit sum
//   master modport: producer/consumer side; slave modport: the adder
interface pipelined_adder_if #(
  parameter int W1 = 16,
  parameter int W2 = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W1-1:0] in1;
  logic [W2-1:0] in2;
  logic          sgn;
  logic          out_valid;
  logic          out_ready;
  logic [W1:0]   out;

  modport master (
    output in_valid, in1, in2, sgn, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in1, in2, sgn, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined W1+W2 adder, CHUNK-bit carry slice per stage
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : pipelined_adder_if.slave (in_valid/in_ready/in1/in2/sgn, out_valid/out_ready/out)
module pipelined_adder #(
  parameter int W1    = 16,
  parameter int W2    = 8,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  pipelined_adder_if.slave bus
);
  localparam int EW     = W1 + 1;
  localparam int STAGES = (EW + CHUNK - 1) / CHUNK;
  localparam logic [EW:0] ONE  = (EW+1)'(1);
  localparam logic [EW:0] MASK = (ONE << CHUNK) - ONE;

  logic          adv;
  logic [EW-1:0] a_ext;
  logic [EW-1:0] b_ext;

  // Per-stage registers. a_q/b_q hold only the operand bits not yet consumed,
  // shifted down so the next stage always reads its slice from the bottom.
  logic [EW-1:0] a_q [STAGES];
  logic [EW-1:0] b_q [STAGES];
  logic [EW-1:0] s_q [STAGES];
  logic          c_q [STAGES];
  logic          v_q [STAGES];

  // Inputs seen by each stage this cycle (stage 0 from the bus, others from k-1).
  logic [EW-1:0] a_src [STAGES];
  logic [EW-1:0] b_src [STAGES];
  logic [EW-1:0] s_src [STAGES];
  logic          c_src [STAGES];
  logic          v_src [STAGES];
  logic [EW:0]   part  [STAGES];

  // Whole pipeline moves in lockstep; only a stalled full output blocks it.
  assign adv          = !reset && (bus.out_ready || !v_q[STAGES-1]);
  assign bus.in_ready = adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out      = s_q[STAGES-1];

  always_comb begin
    a_ext = bus.sgn ? {bus.in1[W1-1], bus.in1} : {1'b0, bus.in1};
    b_ext = bus.sgn ? {{(EW-W2){bus.in2[W2-1]}}, bus.in2} : {{(EW-W2){1'b0}}, bus.in2};
  end

  always_comb begin
    a_src[0] = a_ext;
    b_src[0] = b_ext;
    s_src[0] = '0;
    c_src[0] = 1'b0;
    v_src[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part[k] = ({1'b0, a_src[k]} & MASK) + ({1'b0, b_src[k]} & MASK) + (EW+1)'(c_src[k]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_src[k];
        if (v_src[k]) begin
          a_q[k] <= a_src[k] >> CHUNK;
          b_q[k] <= b_src[k] >> CHUNK;
          c_q[k] <= part[k][CHUNK];
          // Slice lands at its final position; bits past EW (last slice) drop off.
          s_q[k] <= s_src[k] | EW'((part[k] & MASK) << (k * CHUNK));
        end else begin
          // Bubbles carry zero data so out reads 0 whenever out_valid is low.
          a_q[k] <= '0;
          b_q[k] <= '0;
          c_q[k] <= 1'b0;
          s_q[k] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder
module tb_pipelined_adder;
  localparam int W1 = 16;
  localparam int W2 = 8;
  localparam int CHUNK = 4;
  localparam int STAGES = 5;

  logic clock;
  logic reset;

  pipelined_adder_if #(.W1(W1), .W2(W2)) bus ();

  pipelined_adder #(.W1(W1), .W2(W2), .CHUNK(CHUNK)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [7:0]  b;
    logic [16:0] exp;
  } vec_t;

  typedef struct {
    logic [16:0] res;
    int          age;
  } item_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  item_t mq[$];
  int out_cyc[$];
  logic s_ov;
  logic s_ir;
  logic [16:0] s_out;
  vec_t tbl [8];

  function automatic logic [16:0] model_sum(logic s, logic [15:0] a, logic [7:0] b);
    int ia;
    int ib;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    return 17'(ia + ib);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle: sample at negedge, compare against the queue/age model,
  // advance the model across the coming edge, then return just after it.
  task automatic tick();
    logic exp_ov;
    logic exp_adv;
    @(negedge clock);
    s_ov = bus.out_valid;
    s_ir = bus.in_ready;
    s_out = bus.out;
    exp_ov = (mq.size() > 0) && (mq[0].age == 0);
    exp_adv = !reset && (bus.out_ready || !exp_ov);
    check("in_ready", s_ir, exp_adv);
    check("out_valid", s_ov, exp_ov);
    if (exp_ov) check("out", s_out, mq[0].res);
    if (s_ov && bus.out_ready) out_cyc.push_back(cyc);
    if (reset) begin
      mq.delete();
    end else if (exp_adv) begin
      if (exp_ov) void'(mq.pop_front());
      foreach (mq[i]) if (mq[i].age > 0) mq[i].age = mq[i].age - 1;
      if (bus.in_valid) begin
        item_t it;
        it.res = model_sum(bus.sgn, bus.in1, bus.in2);
        it.age = STAGES - 1;
        mq.push_back(it);
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_vec(string name, vec_t v);
    int n;
    bus.in_valid = 1'b1;
    bus.sgn = v.sgn;
    bus.in1 = v.a;
    bus.in2 = v.b;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_ov && n < 20);
    check({name, "_latency"}, n, STAGES);
    check({name, "_value"}, s_out, v.exp);
  endtask

  task automatic check_run(string name, int base, int n);
    check({name, "_count"}, out_cyc.size() - base, n);
    if (out_cyc.size() - base == n)
      for (int j = 0; j < n - 1; j++)
        check({name, "_gap"}, out_cyc[base+j+1] - out_cyc[base+j], 1);
  endtask

  initial begin
    int base;
    logic [16:0] held;

    tbl[0] = '{1'b0, 16'hFFFF, 8'h01, 17'h10000};
    tbl[1] = '{1'b0, 16'h0000, 8'h00, 17'h00000};
    tbl[2] = '{1'b1, 16'hFFFF, 8'h01, 17'h00000};
    tbl[3] = '{1'b1, 16'h7FFF, 8'h01, 17'h08000};
    tbl[4] = '{1'b1, 16'h8000, 8'hFF, 17'h17FFF};
    tbl[5] = '{1'b0, 16'hFFFF, 8'hFF, 17'h100FE};
    tbl[6] = '{1'b1, 16'h0001, 8'h80, 17'h1FF81};
    tbl[7] = '{1'b0, 16'h1234, 8'h56, 17'h0128A};

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.sgn = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_out_valid", s_ov, 1'b0);
    check("reset_out", s_out, 17'h0);

    for (int i = 0; i < 8; i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back, alternating mode.
    base = out_cyc.size();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.sgn = i[0];
      bus.in1 = 16'h8000 + 16'(i);
      bus.in2 = 8'hF0 + 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check_run("b2b", base, 8);

    // Backpressure with a full pipeline.
    for (int i = 0; i < STAGES; i++) begin
      bus.in_valid = 1'b1;
      bus.sgn = 1'b0;
      bus.in1 = 16'h1111 * 16'(i + 1);
      bus.in2 = 8'(i * 7);
      tick();
    end
    bus.out_ready = 1'b0;
    bus.in1 = 16'hAAAA;
    tick();
    held = s_out;
    check("stall_valid", s_ov, 1'b1);
    check("stall_in_ready", s_ir, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_hold", s_out, held);
      check("stall_in_ready", s_ir, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    base = out_cyc.size();
    for (int i = 0; i < 8; i++) tick();
    check_run("drain", base, STAGES);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.sgn = 1'b1;
      bus.in1 = 16'h4000 + 16'(i);
      bus.in2 = 8'h11;
      tick();
    end
    bus.in_valid = 1'b0;
    base = out_cyc.size();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("midreset_out_valid", s_ov, 1'b0);
    check("midreset_out", s_out, 17'h0);
    for (int i = 0; i < 10; i++) tick();
    check("midreset_no_results", out_cyc.size() - base, 0);
    apply_vec("post_reset", tbl[4]);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.sgn = 1'($urandom);
      bus.in1 = 16'($urandom);
      bus.in2 = 8'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("final_empty", mq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined unsigned/signed adder with valid/ready flow control, the successor to the single-width registered adder. It sums a wide operand `in1` and a narrower operand `in2`. The carry chain is split into `CHUNK`-bit slices, one slice per pipeline stage. It sits on the datapath between operand registers and any downstream consumer that can apply backpressure, and sustains one addition per cycle.

## Interface
- `W1`, 16: width of `in1`; result width is `W1+1`.
- `W2`, 8: width of `in2`; must satisfy 1 ≤ `W2` ≤ `W1`.
- `CHUNK`, 4: bits resolved per pipeline stage; 1 ≤ `CHUNK` ≤ `W1+1`.
- Derived `STAGES` = ceil((`W1`+1)/`CHUNK`), which is 5 at the defaults.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and `sgn` are presented this cycle.
- `in_ready`  out  1  the pipeline can accept this cycle.
- `in1`  in  `W1`  first operand.
- `in2`  in  `W2`  second operand.
- `sgn`  in  1  0 selects unsigned, 1 selects two's-complement signed; sampled per transaction.
- `out_valid`  out  1  `out` holds a completed result.
- `out_ready`  in  1  the consumer takes the result this cycle.
- `out`  out  `W1+1`  sum.

## Operation
- **Handshake:** a transfer occurs when valid and ready are both high on a rising edge. This applies to the input side (`in_valid`/`in_ready`) and the output side (`out_valid`/`out_ready`).
- **Advance condition:** `adv` = !`reset` && (`out_ready` || !`out_valid`). All stages shift together when `adv` is high and hold when it is low. There is no bubble collapsing.
- **Ready:** `in_ready` = `adv`, a combinational function of `reset`, `out_ready` and `out_valid` only. It never depends on `in_valid`.
- **Operand extension at accept:** both operands are extended to `W1+1` bits.
  - `sgn`=0: zero-extend both.
  - `sgn`=1: sign-extend both from their own MSB.
- **Stage k** (k = 0..`STAGES`-1):
  - Adds bits [k·`CHUNK` +: `CHUNK`] of the extended operands plus the carry from stage k-1. The carry-in of stage 0 is 0.
  - Registers the partial sum slice, the carry-out, the remaining unconsumed operand bits, and a valid bit.
  - The last slice is truncated to the top of the `W1+1`-bit result.
- **Result:** `out` = (ext(`in1`) + ext(`in2`)) mod 2^(`W1+1`). This is exact for both modes, so overflow is impossible and there is no overflow flag.
- **Per-transaction mode:** `sgn` travels with its operands. Mixed-mode back-to-back transactions must each produce their own correct result.
- **Output hold:** `out` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.

## Timing
- **Reset values:** every stage valid bit = 0, every data register = 0, `out_valid` = 0, `out` = 0. `in_ready` = 0 while `reset` is high.
- **Reset mid-operation:** all in-flight transactions are discarded. No `out_valid` appears for them after `reset` deasserts. The first accept is possible in the first cycle with `reset` low.
- **Latency:** a transaction accepted at edge t shows `out_valid`=1 after edge t+`STAGES`−1, i.e. in cycle t+`STAGES`−1. At the defaults this is `STAGES`=5 register stages from accept to output, given no stalls.
- **Stalls:** each cycle with `adv` low adds exactly one cycle of latency to every in-flight transaction.
- **Throughput:** one transaction per cycle while `out_ready` is held at 1.
- **Simultaneous events:** when `out_valid`=1, `out_ready`=1 and `in_valid`=1 in the same cycle, the output transfer and the input accept both occur. The pipeline shifts with no lost or duplicated result.
- **Bubbles:** an empty stage (valid=0) still shifts on `adv`. Bubbles are not compressed.

## Test plan
All scenarios use the defaults W1=16, W2=8, CHUNK=4.
- **Unsigned carry ripple:** `sgn`=0, `in1`=16'hFFFF, `in2`=8'h01, `out_ready`=1 → `out`=17'h10000 with `out_valid`=1 exactly 5 cycles after accept. Then `in1`=0, `in2`=0 → `out`=0.
- **Signed cases:** each with `sgn`=1.
  - `in1`=16'hFFFF, `in2`=8'h01 → 17'h00000.
  - `in1`=16'h7FFF, `in2`=8'h01 → 17'h08000.
  - `in1`=16'h8000, `in2`=8'hFF → 17'h17FFF.
- **Back-to-back mixed modes:** 8 consecutive accepts alternating `sgn`, operands `in1`=16'h8000+i, `in2`=8'hF0+i → 8 consecutive `out_valid` cycles with the matching results in order, no gaps.
- **Backpressure:** fill the pipeline, hold `out_ready`=0 for 3 cycles.
  - Required: `in_ready`=0, `out` stable, no result lost.
  - On release, results drain in order at one per cycle.
- **Reset mid-flight:** accept 3 transactions, assert `reset` for 1 cycle before any `out_valid`.
  - Required: `out_valid`=0 and `out`=0 after reset.
  - None of the 3 results ever appear.
  - A new transaction then completes in 5 cycles.
